// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - registered branch resolution with optional 2-bit predictor table
// Optional predictor storage is built when BCOMP_BHT_EN is defined.
module branch_unit #(
  parameter int N     = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [2:0]       comp_ctrl,
  input  logic             Branch,
  input  logic             Jump,
  input  logic [N-1:0]     pc_i,
  input  logic             pred_taken_i,
  input  logic [N-1:0]     lookup_pc,
  output logic             pred_taken_o,
  output logic             res_valid,
  output logic [1:0]       PCSrc,
  output logic             taken,
  output logic             mispredict,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mis_cnt
);

  localparam logic [2:0] COMP_EQ  = 3'd0;
  localparam logic [2:0] COMP_NE  = 3'd1;
  localparam logic [2:0] COMP_LT  = 3'd2;
  localparam logic [2:0] COMP_LTU = 3'd3;
  localparam logic [2:0] COMP_GE  = 3'd4;
  localparam logic [2:0] COMP_GEU = 3'd5;
  localparam int IW = $clog2(DEPTH);

  logic             w_cond;
  logic             w_t;
  logic             w_mis;
  logic             w_unused;
  logic             r_res_valid;
  logic [1:0]       r_pcsrc;
  logic             r_taken;
  logic             r_mis;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mis_cnt;

  always_comb begin
    w_cond = 1'b0;
    case (comp_ctrl)
      COMP_EQ:  w_cond = (a == b);
      COMP_NE:  w_cond = (a != b);
      COMP_LT:  w_cond = ($signed(a) < $signed(b));
      COMP_LTU: w_cond = (a < b);
      COMP_GE:  w_cond = ($signed(a) >= $signed(b));
      COMP_GEU: w_cond = (a >= b);
      default:  w_cond = 1'b0;
    endcase
  end

  assign w_t   = Jump ? 1'b1 : (Branch ? w_cond : 1'b0);
  assign w_mis = (w_t != pred_taken_i);

  // Outputs are rebuilt every cycle so an idle cycle reads as all-zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_res_valid <= 1'b0;
      r_pcsrc     <= 2'b00;
      r_taken     <= 1'b0;
      r_mis       <= 1'b0;
      r_br_cnt    <= '0;
      r_mis_cnt   <= '0;
    end else begin
      r_res_valid <= valid_i;
      r_taken     <= valid_i & w_t;
      r_mis       <= valid_i & w_mis;
      if (!valid_i)          r_pcsrc <= 2'b00;
      else if (w_t)          r_pcsrc <= 2'b01;
      else if (pred_taken_i) r_pcsrc <= 2'b10;
      else                   r_pcsrc <= 2'b00;
      if (valid_i && (Branch || Jump) && (r_br_cnt != '1))
        r_br_cnt <= r_br_cnt + CNT_W'(1);
      if (valid_i && w_mis && (r_mis_cnt != '1))
        r_mis_cnt <= r_mis_cnt + CNT_W'(1);
    end
  end

`ifdef BCOMP_BHT_EN
  logic [1:0]    r_bht [DEPTH];
  logic [IW-1:0] w_upd_idx;
  logic [IW-1:0] w_lk_idx;

  assign w_upd_idx    = pc_i[IW+1:2];
  assign w_lk_idx     = lookup_pc[IW+1:2];
  assign pred_taken_o = r_bht[w_lk_idx][1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_bht[i] <= 2'b01;
    end else if (valid_i && Branch && !Jump) begin
      if (w_t && (r_bht[w_upd_idx] != 2'b11))
        r_bht[w_upd_idx] <= r_bht[w_upd_idx] + 2'd1;
      else if (!w_t && (r_bht[w_upd_idx] != 2'b00))
        r_bht[w_upd_idx] <= r_bht[w_upd_idx] - 2'd1;
    end
  end
`else
  assign pred_taken_o = 1'b0;
`endif

  // PC bits outside the index field carry no information for this unit.
  assign w_unused = &{1'b0, pc_i, lookup_pc};

  assign res_valid  = r_res_valid;
  assign PCSrc      = r_pcsrc;
  assign taken      = r_taken;
  assign mispredict = r_mis;
  assign br_cnt     = r_br_cnt;
  assign mis_cnt    = r_mis_cnt;

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - scoreboard bench for branch_unit
module tb_branch_unit;

  localparam logic [2:0] C_EQ  = 3'd0;
  localparam logic [2:0] C_NE  = 3'd1;
  localparam logic [2:0] C_LT  = 3'd2;
  localparam logic [2:0] C_LTU = 3'd3;
  localparam logic [2:0] C_GE  = 3'd4;
  localparam logic [2:0] C_GEU = 3'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic [31:0] a, b;
  logic [2:0]  comp_ctrl;
  logic        Branch, Jump;
  logic [31:0] pc_i;
  logic        pred_taken_i;
  logic [31:0] lookup_pc;
  logic        pred_taken_o;
  logic        res_valid;
  logic [1:0]  PCSrc;
  logic        taken;
  logic        mispredict;
  logic [3:0]  br_cnt, mis_cnt;

  typedef struct {
    logic       t;
    logic [1:0] ps;
    logic       m;
    logic [3:0] bc;
    logic [3:0] mc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_br = 0;
  int   m_mis = 0;
  bit   mon_en = 1'b0;
  logic exp_hit;

  branch_unit #(.N(32), .DEPTH(16), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .a(a), .b(b),
    .comp_ctrl(comp_ctrl), .Branch(Branch), .Jump(Jump), .pc_i(pc_i),
    .pred_taken_i(pred_taken_i), .lookup_pc(lookup_pc),
    .pred_taken_o(pred_taken_o), .res_valid(res_valid), .PCSrc(PCSrc),
    .taken(taken), .mispredict(mispredict), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int sat15(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic step(input logic v, input logic br, input logic jp, input logic [2:0] cc,
                      input logic [31:0] aa, input logic [31:0] bb, input logic [31:0] pc,
                      input logic pt, input logic et, input logic [1:0] ep);
    exp_t e;
    @(posedge clk);
    #1;
    valid_i = v; Branch = br; Jump = jp; comp_ctrl = cc;
    a = aa; b = bb; pc_i = pc; pred_taken_i = pt;
    if (v) begin
      if (br || jp) m_br = sat15(m_br + 1);
      if (et != pt) m_mis = sat15(m_mis + 1);
      e.t = et; e.ps = ep; e.m = et ^ pt;
      e.bc = 4'(m_br); e.mc = 4'(m_mis);
      q.push_back(e);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, C_EQ, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic check_pred(input string name, input logic [31:0] addr, input logic exp);
    lookup_pc = addr;
    #1;
    chk(name, {31'd0, pred_taken_o}, {31'd0, exp});
  endtask

  // Monitor: every resolved result must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (res_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_res_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("taken", {31'd0, taken}, {31'd0, e.t});
          chk("PCSrc", {30'd0, PCSrc}, {30'd0, e.ps});
          chk("mispredict", {31'd0, mispredict}, {31'd0, e.m});
          chk("br_cnt", {28'd0, br_cnt}, {28'd0, e.bc});
          chk("mis_cnt", {28'd0, mis_cnt}, {28'd0, e.mc});
        end
      end else begin
        chk("idle_outputs", {28'd0, PCSrc, taken, mispredict}, 32'd0);
      end
    end
  end

  initial begin
    reset = 1'b1; valid_i = 1'b0; a = '0; b = '0; comp_ctrl = C_EQ;
    Branch = 1'b0; Jump = 1'b0; pc_i = '0; pred_taken_i = 1'b0; lookup_pc = 32'h40;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_PCSrc", {30'd0, PCSrc}, 32'd0);
    chk("rst_br_cnt", {28'd0, br_cnt}, 32'd0);
    chk("rst_mis_cnt", {28'd0, mis_cnt}, 32'd0);
    check_pred("rst_pred_0x40", 32'h40, 1'b0);
    mon_en = 1'b1;

    // signed vs unsigned
    step(1, 1, 0, C_LT,  32'hFFFFFFFF, 32'd1, 32'h110, 0, 1, 2'b01);
    step(1, 1, 0, C_LTU, 32'hFFFFFFFF, 32'd1, 32'h110, 0, 0, 2'b00);

    // predictor training at 0x100 (idx 0)
    step(1, 1, 0, C_EQ, 32'd7, 32'd7, 32'h100, 0, 1, 2'b01);
`ifdef BCOMP_BHT_EN
    check_pred("pred_0x100_before_update", 32'h100, 1'b0);
`endif
    step(1, 1, 0, C_EQ, 32'd7, 32'd7, 32'h100, 0, 1, 2'b01);
`ifdef BCOMP_BHT_EN
    check_pred("pred_0x100_after_first", 32'h100, 1'b1);
`endif
    idle();
`ifdef BCOMP_BHT_EN
    check_pred("pred_0x100_trained", 32'h100, 1'b1);
`else
    check_pred("pred_0x100_no_table", 32'h100, 1'b0);
`endif
    check_pred("pred_0x104_untouched", 32'h104, 1'b0);

    // recovery, jump, GE/GEU, undefined compare, non-branch
    step(1, 1, 0, C_NE,  32'd5, 32'd5, 32'h110, 1, 0, 2'b10);
    step(1, 0, 1, 3'b111, 32'd0, 32'd9, 32'h10C, 0, 1, 2'b01);
    idle();
    check_pred("pred_jump_no_update", 32'h10C, 1'b0);
    step(1, 1, 0, C_GEU, 32'h80000000, 32'd1, 32'h114, 1, 1, 2'b01);
    step(1, 1, 0, C_GE,  32'h80000000, 32'd1, 32'h114, 1, 0, 2'b10);
    step(1, 1, 0, 3'd6,  32'd3, 32'd3, 32'h114, 0, 0, 2'b00);
    step(1, 0, 0, C_EQ,  32'd3, 32'd3, 32'h114, 1, 0, 2'b10);

    // counter saturation at CNT_W=4
    for (int i = 0; i < 20; i++)
      step(1, 1, 0, C_EQ, 32'd1, 32'd2, 32'h108, 1, 0, 2'b10);
    idle();
    @(negedge clk);
    chk("sat_br_cnt", {28'd0, br_cnt}, 32'd15);
    chk("sat_mis_cnt", {28'd0, mis_cnt}, 32'd15);
`ifdef BCOMP_BHT_EN
    check_pred("pred_0x100_before_reset", 32'h100, 1'b1);
`endif

    // mid-stream reset with valid_i held high
    @(posedge clk);
    #1;
    reset = 1'b1; valid_i = 1'b1; Branch = 1'b1; Jump = 1'b0; comp_ctrl = C_EQ;
    a = 32'd1; b = 32'd2; pc_i = 32'h100; pred_taken_i = 1'b1;
    m_br = 0; m_mis = 0;
    @(posedge clk);
    #1;
    reset = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    chk("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("mid_rst_br_cnt", {28'd0, br_cnt}, 32'd0);
    chk("mid_rst_mis_cnt", {28'd0, mis_cnt}, 32'd0);
    check_pred("mid_rst_pred_0x100", 32'h100, 1'b0);

    step(1, 1, 0, C_LTU, 32'd1, 32'd2, 32'h118, 0, 1, 2'b01);
    idle();
    idle();
    @(negedge clk);
    exp_hit = (q.size() == 0);
    chk("scoreboard_drained", {31'd0, exp_hit}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
